// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and helpers for the bit-serial adder.
//                - state_t : controller states (IDLE, SHIFT, DONE)
//                - cnt_w() : bit-counter width for a given operand width
//  Revision    : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter must hold every bit index 0..width-1 plus headroom for
    // width itself, which keeps WIDTH=1 at a legal one-bit counter.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit combinational full adder cell.
//  Ports       : a, b, cin  - addend bits and carry-in
//                sum        - a ^ b ^ cin
//                cout       - majority(a, b, cin)
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial ripple adder. Captures two WIDTH-bit operands and
//                a carry-in, then adds one bit per clock (LSB first) through a
//                single full_adder cell and a carry flop. The final word and
//                carry-out are registered and flagged by a one-cycle done.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                start  - begin an addition (ignored while busy)
//                a, b   - operands, captured on an accepted start
//                cin    - carry-in, captured on an accepted start
//                busy   - high while bits are being processed
//                done   - one-cycle pulse when sum/cout were just updated
//                sum    - registered result, held until next completion
//                cout   - registered carry-out, held until next completion
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic               fa_sum;
    logic               fa_cout;

    full_adder u_full_adder (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result bits enter at the MSB and move right, so after WIDTH steps the
    // first (LSB) result bit has reached bit 0. A one-bit accumulator is just
    // the current sum bit.
    generate
        if (WIDTH == 1) begin : g_acc_single
            assign acc_d = fa_sum;
        end else begin : g_acc_multi
            assign acc_d = {fa_sum, acc_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE accepts a new start exactly like IDLE so continuous
                // start requests run back-to-back without a gap cycle.
                IDLE, DONE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                SHIFT: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + C_ONE;
                    if (cnt_q == C_LAST) begin
                        sum_q   <= acc_d;
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Scoreboard testbench for serial_adder at WIDTH = 8, 1, 13.
//                Stimulus pushes expected results; per-DUT monitors pop and
//                compare on every done pulse and check result hold otherwise.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    typedef struct {
        logic [12:0] s;
        logic        co;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH = 8
    logic       s8, c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    // WIDTH = 1
    logic       s1, c1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    // WIDTH = 13
    logic        s13, c13, busy13, done13, cout13;
    logic [12:0] a13, b13, sum13;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );
    serial_adder #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .start(s13), .a(a13), .b(b13), .cin(c13),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
    );

    exp_t q8[$];
    exp_t q1[$];
    exp_t q13[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s %s", name, what);
    endtask

    // ---------------- monitors ----------------
    exp_t        e8, e1, e13;
    logic [7:0]  h8s;
    logic        h8c;
    logic [0:0]  h1s;
    logic        h1c;
    logic [12:0] h13s;
    logic        h13c;

    always @(negedge clk) begin
        if (!rst_n) begin
            h8s = '0; h8c = 1'b0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                fail("u8_spurious_done", "actual=done required=no_done");
            end else begin
                e8 = q8.pop_front();
                chk("u8_sum", 64'(sum8), 64'(e8.s[7:0]));
                chk("u8_cout", 64'(cout8), 64'(e8.co));
                chk("u8_done_cycle", 64'(cyc), 64'(e8.due));
                h8s = e8.s[7:0];
                h8c = e8.co;
            end
        end else begin
            chk("u8_hold", 64'({cout8, sum8}), 64'({h8c, h8s}));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            h1s = '0; h1c = 1'b0;
        end else if (done1) begin
            if (q1.size() == 0) begin
                fail("u1_spurious_done", "actual=done required=no_done");
            end else begin
                e1 = q1.pop_front();
                chk("u1_sum", 64'(sum1), 64'(e1.s[0]));
                chk("u1_cout", 64'(cout1), 64'(e1.co));
                chk("u1_done_cycle", 64'(cyc), 64'(e1.due));
                h1s = e1.s[0:0];
                h1c = e1.co;
            end
        end else begin
            chk("u1_hold", 64'({cout1, sum1}), 64'({h1c, h1s}));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            h13s = '0; h13c = 1'b0;
        end else if (done13) begin
            if (q13.size() == 0) begin
                fail("u13_spurious_done", "actual=done required=no_done");
            end else begin
                e13 = q13.pop_front();
                chk("u13_sum", 64'(sum13), 64'(e13.s));
                chk("u13_cout", 64'(cout13), 64'(e13.co));
                chk("u13_done_cycle", 64'(cyc), 64'(e13.due));
                h13s = e13.s;
                h13c = e13.co;
            end
        end else begin
            chk("u13_hold", 64'({cout13, sum13}), 64'({h13c, h13s}));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic done_of(input int w);
        case (w)
            1:       return done1;
            8:       return done8;
            default: return done13;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            1:       s1  = v;
            8:       s8  = v;
            default: s13 = v;
        endcase
    endtask

    // Drive one request at a negedge; it is accepted at the next posedge and
    // its result is due WIDTH cycles after that.
    task automatic issue(input int w, input logic [12:0] a, input logic [12:0] b,
                         input logic c, input logic [12:0] es, input logic eco);
        exp_t e;
        @(negedge clk);
        e.s   = es;
        e.co  = eco;
        e.due = cyc + 1 + w;
        case (w)
            1:       begin a1 = a[0:0]; b1 = b[0:0]; c1 = c; q1.push_back(e); end
            8:       begin a8 = a[7:0]; b8 = b[7:0]; c8 = c; q8.push_back(e); end
            default: begin a13 = a;     b13 = b;     c13 = c; q13.push_back(e); end
        endcase
        set_start(w, 1'b1);
    endtask

    task automatic wait_done(input int w, output int at);
        int n = 0;
        while (!done_of(w) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!done_of(w)) fail("done_timeout", "actual=no_done required=done");
        at = cyc;
    endtask

    task automatic run_op(input int w, input logic [12:0] a, input logic [12:0] b,
                          input logic c, input logic [12:0] es, input logic eco);
        int at;
        issue(w, a, b, c, es, eco);
        @(negedge clk);
        set_start(w, 1'b0);
        wait_done(w, at);
    endtask

    // ---------------- main sequence ----------------
    logic [1:0] w1_tab [8];
    logic [8:0]  r9;
    logic [13:0] r14;
    logic [12:0] ra, rb;
    logic        rc;

    initial begin
        int nb, n, d1, d2;
        w1_tab[0] = 2'b00; w1_tab[1] = 2'b01; w1_tab[2] = 2'b01; w1_tab[3] = 2'b10;
        w1_tab[4] = 2'b01; w1_tab[5] = 2'b10; w1_tab[6] = 2'b10; w1_tab[7] = 2'b11;

        rst_n = 1'b0;
        s8 = 0; a8 = '0; b8 = '0; c8 = 0;
        s1 = 0; a1 = '0; b1 = '0; c1 = 0;
        s13 = 0; a13 = '0; b13 = '0; c13 = 0;
        repeat (3) @(negedge clk);
        chk("reset_u8_flags", 64'({busy8, done8, cout8}), 64'd0);
        chk("reset_u8_sum", 64'(sum8), 64'd0);
        chk("reset_u1_outs", 64'({busy1, done1, cout1, sum1}), 64'd0);
        chk("reset_u13_outs", 64'({busy13, done13, cout13, sum13}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0x5A + 0x3C: busy for exactly 8 cycles, then one done cycle.
        issue(8, 13'h5A, 13'h3C, 1'b0, 13'h96, 1'b0);
        @(negedge clk);
        s8 = 1'b0;
        nb = 0; n = 0;
        while (!done8 && n < 64) begin
            if (busy8) nb++;
            @(negedge clk);
            n++;
        end
        chk("t1_busy_cycles", 64'(nb), 64'd8);
        chk("t1_busy_at_done", 64'(busy8), 64'd0);
        @(negedge clk);
        chk("t1_done_one_cycle", 64'(done8), 64'd0);

        // Carry propagation corner cases.
        run_op(8, 13'hFF, 13'h01, 1'b0, 13'h00, 1'b1);
        run_op(8, 13'hFF, 13'h00, 1'b1, 13'h00, 1'b1);
        run_op(8, 13'hFF, 13'hFF, 1'b1, 13'hFF, 1'b1);

        // Reset in the middle of 0xAA + 0x55: no result, no done.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", 64'(busy8), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", 64'({busy8, done8, cout8}), 64'd0);
        chk("rst_mid_sum", 64'(sum8), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_no_done_after", 64'(done8), 64'd0);
        end
        run_op(8, 13'h01, 13'h01, 1'b0, 13'h02, 1'b0);

        // Continuous start: 0x12+0x34 then 0x80+0x80, with a mid-SHIFT
        // re-pulse of start and operand changes that must have no effect.
        issue(8, 13'h12, 13'h34, 1'b0, 13'h46, 1'b0);
        @(negedge clk);
        s8 = 1'b0;
        @(negedge clk);
        s8 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        wait_done(8, d1);
        begin
            exp_t e;
            a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
            e.s = 13'h00; e.co = 1'b1; e.due = cyc + 1 + 8;
            q8.push_back(e);
        end
        @(negedge clk);
        a8 = 8'h13; b8 = 8'h77;
        repeat (3) @(negedge clk);
        s8 = 1'b0;
        wait_done(8, d2);
        chk("b2b_done_spacing", 64'(d2 - d1), 64'd9);

        // WIDTH = 1: full-adder truth table, done one cycle after start.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_op(1, {12'd0, v[2]}, {12'd0, v[1]}, v[0],
                   {12'd0, w1_tab[i][0]}, w1_tab[i][1]);
        end

        // Regression against plain integer addition.
        for (int i = 0; i < 1000; i++) begin
            ra = 13'($urandom); rb = 13'($urandom); rc = 1'($urandom_range(0, 1));
            r9 = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'd0, rc};
            run_op(8, {5'd0, ra[7:0]}, {5'd0, rb[7:0]}, rc, {5'd0, r9[7:0]}, r9[8]);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 13'($urandom); rb = 13'($urandom); rc = 1'($urandom_range(0, 1));
            r14 = {1'b0, ra} + {1'b0, rb} + {13'd0, rc};
            run_op(13, ra, rb, rc, r14[12:0], r14[13]);
        end

        repeat (4) @(negedge clk);
        chk("u8_queue_drained", 64'(q8.size()), 64'd0);
        chk("u1_queue_drained", 64'(q1.size()), 64'd0);
        chk("u13_queue_drained", 64'(q13.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_adder
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder built on the existing full_adder cell. It is the next stage that consumes full_adder's sum/cout.
- Loads two WIDTH-bit operands and a carry-in, then processes one bit per clock, LSB first, through a single full_adder instance and a carry flop.
- Result and carry-out are presented as a registered word with a one-cycle done pulse.
- Serves as the area-minimal adder option for datapaths that can tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled only when not busy
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse: sum/cout just updated
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out, held until next completion

Behaviour:
- Reset: the block has one clock and an asynchronous, active-low reset (rst_n). Asserting rst_n=0 immediately forces:
  - state=IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - internal shift registers, carry flop and bit counter = 0.
- Reset mid-operation aborts the addition. No done pulse follows, and no partial result is exposed.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge T0: capture a, b into shift regs; carry flop <= cin; count <= 0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Each edge: full_adder inputs are a_sh[0], b_sh[0], carry.
  - Its sum bit shifts into the MSB of an internal accumulator. Its cout goes to the carry flop.
  - a_sh and b_sh shift right, zero-filled. count increments.
  - On the edge processing bit WIDTH-1 (edge T_WIDTH): sum <= final accumulator value (including this bit); cout <= full_adder cout; go to DONE.
- DONE: done=1 for exactly that one cycle.
  - start=1: accepted, same capture as IDLE, go to SHIFT. Back-to-back operation adds no idle cycle.
  - start=0: go to IDLE.
- busy is 1 in SHIFT only, i.e. for cycles T0+ through T_WIDTH-. done is 1 in DONE only.
- Latency: start sampled at T0 → done high in the cycle after edge T_WIDTH (WIDTH cycles). Throughput: one result per WIDTH+1 cycles with continuous start.
- start while busy=1 is ignored and not queued. Operand changes during SHIFT have no effect.
- sum/cout change only on a completion edge (or reset). They are stable during a subsequent operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- Counter width: $clog2(WIDTH+1). With WIDTH=1, SHIFT lasts exactly one edge.

Decomposition:
- Package serial_adder_pkg:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE};
  - function cnt_w(width) returning $clog2(width+1).
- Sub-module: exactly one instance of the existing full_adder (port order a, b, cin, sum, cout), used as the per-bit combinational cell. No further sub-modules.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse → busy high 8 cycles; done one cycle; sum=0x96, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start held high continuously with a=0x12, b=0x34 then a=0x80, b=0x80 (changed at done) → results 0x46/0 then 0x00/1. Done pulses spaced 9 cycles apart. A start re-pulsed mid-SHIFT is ignored, and a/b changes during SHIFT do not alter the result.
- Reset mid-SHIFT: rst_n low at cycle 4 of a=0xAA+b=0x55 → outputs 0 immediately. No done after release. Next start with 0x01+0x01 → sum=0x02.
- WIDTH=1: all 8 {a,b,cin} combinations → {cout,sum} matches the full-adder truth table (000→00, 001→01, 011→10, 111→11, …). Done occurs one cycle after start.
- Random regression: 1000 operations at WIDTH=8 and WIDTH=13, compared against a+b+cin. sum/cout are checked to be stable whenever done=0.
